// File: rtl/lcd_pkg.sv
// Shared constants for the character-LCD refresh controller: sequencer
// states, HD44780-style command bytes and a screen-buffer char accessor.
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_POWERUP,
        ST_FUNC_SET,
        ST_DISP_ON,
        ST_ENTRY,
        ST_CLEAR,
        ST_CLEAR_WAIT,
        ST_SNAP,
        ST_L1_ADDR,
        ST_L1_CHAR,
        ST_L2_ADDR,
        ST_L2_CHAR
    } lcd_state_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // auto-increment, no shift
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] CMD_LINE2    = 8'hC0;  // DDRAM address 0x40
    localparam logic [7:0] CHAR_SPACE   = 8'h20;

    localparam logic [4:0] LAST_L1_IDX  = 5'd15;
    localparam logic [4:0] LAST_L2_IDX  = 5'd31;

    // Char idx of a 32-char screen vector lives at bits [8*idx+7 : 8*idx].
    function automatic logic [7:0] char_at(input logic [255:0] scr, input logic [4:0] idx);
        return scr[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lcd_refresh_ctrl_if.sv
// LCD pin bundle. The controller drives it (master); the pad ring or a
// bus monitor observes it (slave).
interface lcd_refresh_ctrl_if;

    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;

    modport master (output LCD_E, LCD_RS, LCD_RW, LCD_DATA);
    modport slave  (input  LCD_E, LCD_RS, LCD_RW, LCD_DATA);

endinterface

// File: rtl/lcd_bus_step.sv
// One LCD bus transfer. A start pulse latches RS/byte; the step then lasts
// STEP_CYCLES cycles with E high for k = 1..STEP_CYCLES/2, giving at least
// one cycle of setup before E rises and one of hold after it falls. RS and
// DATA keep their last value between steps. A start in the same cycle as
// done chains the next step with no gap.
module lcd_bus_step #(
    parameter int STEP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs_in,
    input  logic [7:0] byte_in,
    output logic       e,
    output logic       rs,
    output logic [7:0] data,
    output logic       done
);

    localparam int KW   = $clog2(STEP_CYCLES);
    localparam int HALF = STEP_CYCLES / 2;

    logic [KW-1:0] k;
    logic          busy;

    assign done = busy && (k == KW'(STEP_CYCLES - 1));

    // Step counter and registered bus outputs; reset drops E immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            k    <= '0;
            e    <= 1'b0;
            rs   <= 1'b0;
            data <= 8'h00;
        end else if (start) begin
            busy <= 1'b1;
            k    <= '0;
            e    <= 1'b0;
            rs   <= rs_in;
            data <= byte_in;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
                k    <= '0;
                e    <= 1'b0;
            end else begin
                k <= k + 1'b1;
                // E for the coming cycle k+1: high while k+1 <= HALF
                e <= (k < KW'(HALF));
            end
        end
    end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// 16x2 LCD sequencer: power-up wait, one-shot init commands, then an
// endless refresh of both lines from a per-frame snapshot of SCREEN_DATA.
// Each bus step is launched on the cycle the FSM moves into (or re-enters)
// a bus state, so consecutive steps run back to back.
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int STEP_CYCLES       = 4,
    parameter int POWERUP_CYCLES    = 40,
    parameter int CLEAR_WAIT_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [255:0]        SCREEN_DATA,
    lcd_refresh_ctrl_if.master  lcd,
    output logic                INIT_DONE,
    output logic                FRAME_DONE
);

    lcd_state_e    state, state_nxt;
    logic [15:0]   wait_cnt, wait_nxt;
    logic [4:0]    char_idx, idx_nxt;
    logic [255:0]  snapshot;
    logic          init_nxt, fdone_nxt, snap_ld;
    logic          step_start, step_rs, step_done;
    logic [7:0]    step_byte;

    assign lcd.LCD_RW = 1'b0;

    lcd_bus_step #(.STEP_CYCLES(STEP_CYCLES)) u_step (
        .clk     (CLK),
        .rst     (RESET),
        .start   (step_start),
        .rs_in   (step_rs),
        .byte_in (step_byte),
        .e       (lcd.LCD_E),
        .rs      (lcd.LCD_RS),
        .data    (lcd.LCD_DATA),
        .done    (step_done)
    );

    // State, counters, status flags and the frame snapshot.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_POWERUP;
            wait_cnt   <= '0;
            char_idx   <= '0;
            INIT_DONE  <= 1'b0;
            FRAME_DONE <= 1'b0;
            snapshot   <= {32{CHAR_SPACE}};
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_nxt;
            char_idx   <= idx_nxt;
            INIT_DONE  <= init_nxt;
            FRAME_DONE <= fdone_nxt;
            if (snap_ld)
                snapshot <= SCREEN_DATA;
        end
    end

    // Next state, step launch with its RS/byte, counter updates.
    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        idx_nxt    = char_idx;
        init_nxt   = INIT_DONE;
        fdone_nxt  = 1'b0;
        snap_ld    = 1'b0;
        step_start = 1'b0;
        step_rs    = 1'b0;
        step_byte  = 8'h00;

        case (state)
            ST_POWERUP: begin
                if (wait_cnt == 16'(POWERUP_CYCLES - 1)) begin
                    state_nxt  = ST_FUNC_SET;
                    wait_nxt   = '0;
                    step_start = 1'b1;
                    step_byte  = CMD_FUNC_SET;
                end else begin
                    wait_nxt = wait_cnt + 16'd1;
                end
            end
            ST_FUNC_SET: begin
                if (step_done) begin
                    state_nxt  = ST_DISP_ON;
                    step_start = 1'b1;
                    step_byte  = CMD_DISP_ON;
                end
            end
            ST_DISP_ON: begin
                if (step_done) begin
                    state_nxt  = ST_ENTRY;
                    step_start = 1'b1;
                    step_byte  = CMD_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (step_done) begin
                    state_nxt  = ST_CLEAR;
                    step_start = 1'b1;
                    step_byte  = CMD_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (step_done) begin
                    state_nxt = ST_CLEAR_WAIT;
                    wait_nxt  = '0;
                end
            end
            ST_CLEAR_WAIT: begin
                // clear-display needs extra settle time before any write
                if (wait_cnt == 16'(CLEAR_WAIT_CYCLES - 1)) begin
                    state_nxt = ST_SNAP;
                    wait_nxt  = '0;
                    init_nxt  = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 16'd1;
                end
            end
            ST_SNAP: begin
                snap_ld    = 1'b1;
                state_nxt  = ST_L1_ADDR;
                step_start = 1'b1;
                step_byte  = CMD_LINE1;
            end
            ST_L1_ADDR: begin
                if (step_done) begin
                    state_nxt  = ST_L1_CHAR;
                    step_start = 1'b1;
                    step_rs    = 1'b1;
                    step_byte  = char_at(snapshot, char_idx);
                end
            end
            ST_L1_CHAR: begin
                if (step_done) begin
                    idx_nxt    = char_idx + 5'd1;
                    step_start = 1'b1;
                    if (char_idx == LAST_L1_IDX) begin
                        state_nxt = ST_L2_ADDR;
                        step_byte = CMD_LINE2;
                    end else begin
                        step_rs   = 1'b1;
                        step_byte = char_at(snapshot, char_idx + 5'd1);
                    end
                end
            end
            ST_L2_ADDR: begin
                if (step_done) begin
                    state_nxt  = ST_L2_CHAR;
                    step_start = 1'b1;
                    step_rs    = 1'b1;
                    step_byte  = char_at(snapshot, char_idx);
                end
            end
            ST_L2_CHAR: begin
                if (step_done) begin
                    // 5-bit index wraps 31 -> 0 for the next frame
                    idx_nxt = char_idx + 5'd1;
                    if (char_idx == LAST_L2_IDX) begin
                        state_nxt = ST_SNAP;
                        fdone_nxt = 1'b1;
                    end else begin
                        step_start = 1'b1;
                        step_rs    = 1'b1;
                        step_byte  = char_at(snapshot, char_idx + 5'd1);
                    end
                end
            end
            default: begin
                state_nxt = ST_POWERUP;
                wait_nxt  = '0;
            end
        endcase
    end

endmodule
